frog_lives_fsm: RTL and testbench
=================================

// Module: frog_lives_fsm
// PURPOSE
//  Downstream consumer of the 8-input "frog lost" OR (collision/drown/timeout sources merged).
//  Turns that level signal into game progression:
//   - counts down remaining lives
//   - holds a respawn (invulnerable) interval after each death
//   - issues a one-cycle respawn pulse that returns the frog to the start position
//   - declares game over; the start button restarts the game
// PARAMETERS
//  LIVES_INIT      3           lives loaded on start/restart; 1..2**LIVES_WIDTH-1
//  LIVES_WIDTH     2           width of lives counter/output
//  RESPAWN_CYCLES  50000000    clock cycles spent in DYING (1 s @ 50 MHz); >=1
//  CNT_WIDTH       26          respawn counter width; must hold RESPAWN_CYCLES-1
// PORTS
//  SC_LIVES_CLOCK_50      in   1            system clock, rising edge
//  SC_LIVES_RESET_InLow   in   1            asynchronous active-low reset
//  SC_LIVES_hit_In        in   1            level "frog lost" from the 8-input OR
//  SC_LIVES_start_In      in   1            start/restart request, synchronous, already debounced
//  SC_LIVES_lives_Out     out  LIVES_WIDTH  remaining lives
//  SC_LIVES_playing_Out   out  1            1 in PLAY; enables frog movement and hazards
//  SC_LIVES_invuln_Out    out  1            1 in DYING
//  SC_LIVES_respawn_Out   out  1            one-cycle pulse: reset frog position
//  SC_LIVES_gameover_Out  out  1            1 in GAMEOVER
// BEHAVIOUR
//  Outputs and state:
//   - all outputs registered
//   - input sampled at edge k -> response visible after edge k (1-cycle latency)
//   - states: IDLE, PLAY, DYING, GAMEOVER
//  Reset (async, on RESET_InLow=0):
//   - state=IDLE, lives=LIVES_INIT, counter=0, armed=0
//   - playing=invuln=respawn=gameover=0
//  Arming:
//   - armed=0 on entry to PLAY
//   - armed=1 after first sampled cycle in PLAY with hit=0
//   - hit is acted on only when armed=1, so a collision still present at respawn is not double-counted
//  Transitions:
//   - IDLE: start=1 -> PLAY; lives=LIVES_INIT; respawn pulse; hit ignored
//   - PLAY: armed & hit & lives>1 -> DYING; lives-=1; counter=RESPAWN_CYCLES-1
//   - PLAY: armed & hit & lives==1 -> GAMEOVER; lives=0
//   - PLAY: start ignored
//   - DYING: counter decrements each cycle; at counter==0 -> PLAY with respawn pulse
//            (DYING lasts exactly RESPAWN_CYCLES cycles)
//   - DYING: hit and start ignored
//   - GAMEOVER: start=1 -> PLAY; lives=LIVES_INIT; respawn pulse; hit ignored
//  Boundaries:
//   - lives never wraps below 0; decrement happens only from values >=1
//   - hit and start in the same cycle: in PLAY the hit is taken and start is ignored;
//     in IDLE/GAMEOVER start wins
//   - reset mid-DYING or mid-GAMEOVER: immediate return to IDLE values; no respawn pulse
//   - undefined state encodings recover to IDLE
// TESTING (LIVES_INIT=3, RESPAWN_CYCLES=4)
//  1. Reset low, then high: IDLE, lives=3, all flags 0.
//     Start for 1 cycle: playing=1, respawn=1 for exactly 1 cycle.
//  2. Hold hit 1 cycle while armed: lives=2, invuln=1 for exactly 4 cycles,
//     then respawn pulse and playing=1.
//  3. Hold hit high across death and respawn: exactly one decrement.
//     Next decrement only after hit has been low >=1 cycle and then goes high again.
//  4. Three separate hits: lives 3->2->1->0, gameover=1, playing=0.
//     Further hits: no change. Start: lives=3, playing=1, respawn pulse.
//  5. Reset low during cycle 2 of DYING: outputs go to IDLE values asynchronously;
//     after release, lives=3 and no respawn pulse.
//  6. Start pulses during PLAY and during DYING: no state, lives or counter change.

Source files
------------

// File: rtl/frog_lives_fsm_if.sv
// Game-side connection for the frog lives controller.
// Carries the merged "frog lost" level and the start/restart request into the
// controller, and the lives count plus game-phase flags back out.
//   SC_LIVES_hit_In        level "frog lost" (OR of collision/drown/timeout)
//   SC_LIVES_start_In      start/restart request, synchronous, debounced
//   SC_LIVES_lives_Out     remaining lives
//   SC_LIVES_playing_Out   frog movement and hazards enabled
//   SC_LIVES_invuln_Out    respawn (invulnerable) interval in progress
//   SC_LIVES_respawn_Out   one-cycle pulse: return frog to start position
//   SC_LIVES_gameover_Out  game over
// Modports: master = game logic (drives hit/start), slave = lives controller.
interface frog_lives_fsm_if #(
  parameter int LIVES_WIDTH = 2
);
  logic                   SC_LIVES_hit_In;
  logic                   SC_LIVES_start_In;
  logic [LIVES_WIDTH-1:0] SC_LIVES_lives_Out;
  logic                   SC_LIVES_playing_Out;
  logic                   SC_LIVES_invuln_Out;
  logic                   SC_LIVES_respawn_Out;
  logic                   SC_LIVES_gameover_Out;

  modport master (
    output SC_LIVES_hit_In,
    output SC_LIVES_start_In,
    input  SC_LIVES_lives_Out,
    input  SC_LIVES_playing_Out,
    input  SC_LIVES_invuln_Out,
    input  SC_LIVES_respawn_Out,
    input  SC_LIVES_gameover_Out
  );

  modport slave (
    input  SC_LIVES_hit_In,
    input  SC_LIVES_start_In,
    output SC_LIVES_lives_Out,
    output SC_LIVES_playing_Out,
    output SC_LIVES_invuln_Out,
    output SC_LIVES_respawn_Out,
    output SC_LIVES_gameover_Out
  );
endinterface

// File: rtl/frog_lives_fsm.sv
// Frog lives controller: turns the merged "frog lost" level into game
// progression -- lives countdown, a timed invulnerable respawn interval,
// a one-cycle respawn pulse and game over, with start/restart.
// Ports:
//   SC_LIVES_CLOCK_50     system clock, rising edge
//   SC_LIVES_RESET_InLow  asynchronous active-low reset
//   bus                   frog_lives_fsm_if.slave (hit/start in, lives/flags out)
// All outputs are registered: an input sampled at edge k shows its effect
// right after edge k.
module frog_lives_fsm #(
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_WIDTH    = 2,
  parameter int RESPAWN_CYCLES = 50000000,
  parameter int CNT_WIDTH      = 26
) (
  input  logic                SC_LIVES_CLOCK_50,
  input  logic                SC_LIVES_RESET_InLow,
  frog_lives_fsm_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    DYING    = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ONE  = LIVES_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_LOAD   = CNT_WIDTH'(RESPAWN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);

  state_t                 state;
  logic [LIVES_WIDTH-1:0] lives;
  logic [CNT_WIDTH-1:0]   counter;
  // Set once hit has been seen low in PLAY; blocks a collision that is still
  // asserted at respawn from costing a second life.
  logic                   armed;
  logic                   playing;
  logic                   invuln;
  logic                   respawn;
  logic                   gameover;

  always_ff @(posedge SC_LIVES_CLOCK_50 or negedge SC_LIVES_RESET_InLow) begin
    if (!SC_LIVES_RESET_InLow) begin
      state    <= IDLE;
      lives    <= LIVES_LOAD;
      counter  <= '0;
      armed    <= 1'b0;
      playing  <= 1'b0;
      invuln   <= 1'b0;
      respawn  <= 1'b0;
      gameover <= 1'b0;
    end else begin
      respawn <= 1'b0;
      case (state)
        IDLE, GAMEOVER: begin
          if (bus.SC_LIVES_start_In) begin
            state    <= PLAY;
            lives    <= LIVES_LOAD;
            armed    <= 1'b0;
            playing  <= 1'b1;
            invuln   <= 1'b0;
            respawn  <= 1'b1;
            gameover <= 1'b0;
          end
        end

        PLAY: begin
          if (armed && bus.SC_LIVES_hit_In) begin
            playing <= 1'b0;
            armed   <= 1'b0;
            if (lives > LIVES_ONE) begin
              state   <= DYING;
              lives   <= lives - LIVES_ONE;
              counter <= CNT_LOAD;
              invuln  <= 1'b1;
            end else begin
              // Last life (or none left): clamp at zero, never wrap.
              state    <= GAMEOVER;
              lives    <= '0;
              gameover <= 1'b1;
            end
          end else if (!bus.SC_LIVES_hit_In) begin
            armed <= 1'b1;
          end
        end

        DYING: begin
          if (counter == '0) begin
            state   <= PLAY;
            armed   <= 1'b0;
            playing <= 1'b1;
            invuln  <= 1'b0;
            respawn <= 1'b1;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          lives    <= LIVES_LOAD;
          counter  <= '0;
          armed    <= 1'b0;
          playing  <= 1'b0;
          invuln   <= 1'b0;
          gameover <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SC_LIVES_lives_Out    = lives;
  assign bus.SC_LIVES_playing_Out  = playing;
  assign bus.SC_LIVES_invuln_Out   = invuln;
  assign bus.SC_LIVES_respawn_Out  = respawn;
  assign bus.SC_LIVES_gameover_Out = gameover;

endmodule

// File: tb/tb_frog_lives_fsm.sv
// Testbench for frog_lives_fsm (LIVES_INIT=3, RESPAWN_CYCLES=4): directed
// scenarios with literal expectations, then randomized hit/start/reset
// traffic checked every cycle against a behavioural game model.
module tb_frog_lives_fsm;

  localparam int LI = 3;
  localparam int LW = 2;
  localparam int RC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   cmp_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  frog_lives_fsm_if #(.LIVES_WIDTH(LW)) bus ();

  frog_lives_fsm #(
    .LIVES_INIT(LI), .LIVES_WIDTH(LW), .RESPAWN_CYCLES(RC), .CNT_WIDTH(CW)
  ) dut (
    .SC_LIVES_CLOCK_50   (clk),
    .SC_LIVES_RESET_InLow(rst_n),
    .bus                 (bus)
  );

  // Behavioural model: game started?, game over?, lives, cycles of
  // invulnerability remaining, whether hit has been seen low since the
  // frog (re)appeared, and whether a respawn happened on this edge.
  bit m_started = 1'b0;
  bit m_over    = 1'b0;
  int m_lives   = LI;
  int m_dying   = 0;
  bit m_armed   = 1'b0;
  bit m_resp    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0; m_over = 1'b0; m_lives = LI;
      m_dying = 0; m_armed = 1'b0; m_resp = 1'b0;
    end else begin
      m_resp = 1'b0;
      if (!m_started || m_over) begin
        if (bus.SC_LIVES_start_In) begin
          m_started = 1'b1; m_over = 1'b0; m_lives = LI;
          m_dying = 0; m_armed = 1'b0; m_resp = 1'b1;
        end
      end else if (m_dying > 0) begin
        m_dying = m_dying - 1;
        if (m_dying == 0) begin
          m_resp = 1'b1; m_armed = 1'b0;
        end
      end else begin
        if (m_armed && bus.SC_LIVES_hit_In) begin
          m_armed = 1'b0;
          if (m_lives > 1) begin
            m_lives = m_lives - 1; m_dying = RC;
          end else begin
            m_lives = 0; m_over = 1'b1;
          end
        end else if (!bus.SC_LIVES_hit_In) begin
          m_armed = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: {lives, playing, invuln, respawn, gameover}.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [LW+3:0] act, exp;
      act = {bus.SC_LIVES_lives_Out, bus.SC_LIVES_playing_Out, bus.SC_LIVES_invuln_Out,
             bus.SC_LIVES_respawn_Out, bus.SC_LIVES_gameover_Out};
      exp = {LW'(m_lives), (m_started && !m_over && m_dying == 0), (m_dying > 0),
             m_resp, m_over};
      check("model", int'(act), int'(exp));
    end
  end

  // Apply inputs away from the edge, then look just after the next edge.
  task automatic step(input bit h, input bit s);
    @(negedge clk); #1;
    bus.SC_LIVES_hit_In   = h;
    bus.SC_LIVES_start_In = s;
    @(posedge clk); #1;
  endtask

  function automatic int outs();
    return {bus.SC_LIVES_lives_Out, bus.SC_LIVES_playing_Out, bus.SC_LIVES_invuln_Out,
            bus.SC_LIVES_respawn_Out, bus.SC_LIVES_gameover_Out};
  endfunction

  // Literal output word: lives<<4 | playing<<3 | invuln<<2 | respawn<<1 | gameover
  function automatic int w(int l, bit p, bit i, bit r, bit g);
    return (l << 4) | (p << 3) | (i << 2) | (r << 1) | g;
  endfunction

  initial begin
    bus.SC_LIVES_hit_In   = 1'b0;
    bus.SC_LIVES_start_In = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1 check("reset_vals", outs(), w(3, 0, 0, 0, 0));
    rst_n = 1'b1;

    // 1. start from IDLE
    step(0, 1); check("start_pulse", outs(), w(3, 1, 0, 1, 0));
    step(0, 0); check("pulse_one_cycle", outs(), w(3, 1, 0, 0, 0));

    // 2. single hit while armed: 4 invulnerable cycles then respawn
    step(1, 0); check("hit_dying", outs(), w(2, 0, 1, 0, 0));
    step(0, 0); step(0, 0); step(0, 0);
    check("dying_4th", outs(), w(2, 0, 1, 0, 0));
    step(0, 0); check("respawn", outs(), w(2, 1, 0, 1, 0));

    // 3. hit held across death and respawn costs exactly one life
    step(0, 0);
    repeat (8) step(1, 0);
    check("held_hit_once", outs(), w(1, 1, 0, 0, 0));

    // 4. last life -> game over; hits ignored; start (with hit) restarts
    step(0, 0);
    step(1, 0); check("gameover", outs(), w(0, 0, 0, 0, 1));
    repeat (3) step(1, 0);
    check("gameover_hold", outs(), w(0, 0, 0, 0, 1));
    step(1, 1); check("restart", outs(), w(3, 1, 0, 1, 0));

    // 5. async reset during cycle 2 of DYING
    step(0, 0);
    step(1, 0); step(0, 0);
    check("dying_c2", outs(), w(2, 0, 1, 0, 0));
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), w(3, 0, 0, 0, 0));
    @(negedge clk); #2 rst_n = 1'b1;
    step(0, 0); check("after_reset", outs(), w(3, 0, 0, 0, 0));

    // 6. start in PLAY and DYING changes nothing
    step(0, 1); step(0, 0);
    step(0, 1); check("start_in_play", outs(), w(3, 1, 0, 0, 0));
    step(1, 1); check("hit_beats_start", outs(), w(2, 0, 1, 0, 0));
    repeat (3) step(0, 1);
    check("start_in_dying", outs(), w(2, 0, 1, 0, 0));
    step(0, 1); check("dying_len", outs(), w(2, 1, 0, 1, 0));

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 8);
    end

    @(negedge clk); #1;
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
